// File: rtl/matmul_tile_sequencer_if.sv
// Operand-fetch, kernel and result-tile signal bundle for the matmul tile sequencer.
// The sequencer takes the master side; buffers, kernel and result writer take the slave side.
interface matmul_tile_sequencer_if #(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int K  = 2,
  parameter int P  = 8,
  parameter int CW = 8
);
  logic                      op_req;
  logic [CW-1:0]             op_m_idx;
  logic [CW-1:0]             op_n_idx;
  logic [CW-1:0]             op_k_idx;
  logic                      op_valid;
  logic [M*K-1:0][P-1:0]     op_a;
  logic [K*N-1:0][P-1:0]     op_b;
  logic [M*K-1:0][P-1:0]     kern_a;
  logic [K*N-1:0][P-1:0]     kern_b;
  logic [M*N-1:0][4*P-1:0]   kern_c;
  logic [M*N-1:0][4*P-1:0]   kern_d;
  logic                      res_valid;
  logic                      res_ready;
  logic [M*N-1:0][4*P-1:0]   res_data;
  logic [CW-1:0]             res_m_idx;
  logic [CW-1:0]             res_n_idx;

  modport master (
    output op_req, op_m_idx, op_n_idx, op_k_idx,
    input  op_valid, op_a, op_b,
    output kern_a, kern_b, kern_c,
    input  kern_d,
    output res_valid, res_data, res_m_idx, res_n_idx,
    input  res_ready
  );

  modport slave (
    input  op_req, op_m_idx, op_n_idx, op_k_idx,
    output op_valid, op_a, op_b,
    input  kern_a, kern_b, kern_c,
    output kern_d,
    input  res_valid, res_data, res_m_idx, res_n_idx,
    output res_ready
  );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// Walks an MT x NT x KT tile job (mt, nt, kt innermost), feeding an external D = A*B + C
// kernel and folding D back into C until each output tile is complete.
module matmul_tile_sequencer #(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int K  = 2,
  parameter int P  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_mt,
  input  logic [CW-1:0] cfg_nt,
  input  logic [CW-1:0] cfg_kt,
  output logic          busy,
  output logic          done,
  matmul_tile_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACC, S_OUT, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic [CW-1:0]           r_mt_cnt, r_nt_cnt, r_kt_cnt;
  logic [CW-1:0]           r_mt, r_nt, r_kt;
  logic [M*K-1:0][P-1:0]   r_a;
  logic [K*N-1:0][P-1:0]   r_b;
  logic [M*N-1:0][4*P-1:0] r_acc;
  logic                    w_cfg_zero, w_kt_last, w_nt_last, w_mt_last;

  assign w_cfg_zero = (cfg_mt == '0) || (cfg_nt == '0) || (cfg_kt == '0);
  assign w_kt_last  = (r_kt == r_kt_cnt - CW'(1));
  assign w_nt_last  = (r_nt == r_nt_cnt - CW'(1));
  assign w_mt_last  = (r_mt == r_mt_cnt - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_cfg_zero ? S_DONE : S_FETCH;
      S_FETCH: if (bus.op_valid) w_next = S_ACC;
      S_ACC:   w_next = w_kt_last ? S_OUT : S_FETCH;
      S_OUT:   if (bus.res_ready) w_next = (w_nt_last && w_mt_last) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.op_req    = (r_state == S_FETCH);
    bus.res_valid = (r_state == S_OUT);
    done          = (r_state == S_DONE);
    busy          = (r_state != S_IDLE);
  end

  // Counters and the accumulator only move on the transitions that own them, so
  // indices and result data stay frozen while a handshake is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mt_cnt <= '0;
      r_nt_cnt <= '0;
      r_kt_cnt <= '0;
      r_mt     <= '0;
      r_nt     <= '0;
      r_kt     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mt_cnt <= cfg_mt;
          r_nt_cnt <= cfg_nt;
          r_kt_cnt <= cfg_kt;
          r_mt     <= '0;
          r_nt     <= '0;
          r_kt     <= '0;
          r_acc    <= '0;
        end
        S_FETCH: if (bus.op_valid) begin
          r_a <= bus.op_a;
          r_b <= bus.op_b;
        end
        S_ACC: begin
          r_acc <= bus.kern_d;
          if (!w_kt_last) r_kt <= r_kt + CW'(1);
        end
        S_OUT: if (bus.res_ready) begin
          r_acc <= '0;
          r_kt  <= '0;
          if (!w_nt_last) begin
            r_nt <= r_nt + CW'(1);
          end else if (!w_mt_last) begin
            r_nt <= '0;
            r_mt <= r_mt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.op_m_idx  = r_mt;
  assign bus.op_n_idx  = r_nt;
  assign bus.op_k_idx  = r_kt;
  assign bus.kern_a    = r_a;
  assign bus.kern_b    = r_b;
  assign bus.kern_c    = r_acc;
  assign bus.res_data  = r_acc;
  assign bus.res_m_idx = r_mt;
  assign bus.res_n_idx = r_nt;
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Self-checking bench: behavioural kernel, operand responder and result sink driven
// from one directed sequence; expected tiles come from whole-matrix arithmetic.
module tb_matmul_tile_sequencer;
  localparam int M = 2, N = 2, K = 2, P = 8, CW = 8;

  typedef logic [M*K-1:0][P-1:0]   a_t;
  typedef logic [K*N-1:0][P-1:0]   b_t;
  typedef logic [M*N-1:0][4*P-1:0] r_t;

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic [CW-1:0] cfg_mt, cfg_nt, cfg_kt;

  matmul_tile_sequencer_if #(.M(M), .N(N), .K(K), .P(P), .CW(CW)) bus ();

  matmul_tile_sequencer #(.M(M), .N(N), .K(K), .P(P), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_mt(cfg_mt), .cfg_nt(cfg_nt), .cfg_kt(cfg_kt),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // External kernel: D = A*B + C, signed operands, 32-bit wrapping sums.
  always_comb begin
    bus.kern_d = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = int'(bus.kern_c[i*N+j]);
        for (int l = 0; l < K; l++)
          s = s + int'($signed(bus.kern_a[i*K+l])) * int'($signed(bus.kern_b[l*N+j]));
        bus.kern_d[i*N+j] = s;
      end
  end

  int n_pass = 0, n_total = 0;
  logic signed [P-1:0] ta  [3][3][M][K];  // [m][k] A tiles
  logic signed [P-1:0] tbt [3][3][K][N];  // [k][n] B tiles
  r_t last_res;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic a_t pack_a(int m, int k);
    a_t r;
    for (int i = 0; i < M; i++) for (int j = 0; j < K; j++) r[i*K+j] = ta[m][k][i][j];
    return r;
  endfunction

  function automatic b_t pack_b(int k, int n);
    b_t r;
    for (int i = 0; i < K; i++) for (int j = 0; j < N; j++) r[i*N+j] = tbt[k][n][i][j];
    return r;
  endfunction

  // Output tile (m,n) of the full product: row block m of A times column block n of B.
  function automatic r_t exp_tile(int m, int n, int kt);
    r_t r;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < kt; k++)
          for (int l = 0; l < K; l++)
            s += int'(ta[m][k][i][l]) * int'(tbt[k][n][l][j]);
        r[i*N+j] = s;
      end
    return r;
  endfunction

  task automatic fill_rand();
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++)
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
        ta[a][b][i][j]  = P'($urandom);
        tbt[a][b][i][j] = P'($urandom);
      end
  endtask

  task automatic fill_const(int av, int bv);
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++)
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
        ta[a][b][i][j]  = P'(av);
        tbt[a][b][i][j] = P'(bv);
      end
  endtask

  task automatic run_job(int mt, int nt, int kt, int op_dly, int rdy_dly, bit poke);
    int em = 0, en = 0, ek = 0, ops = 0, ress = 0, cyc, last_hs = -1, w_op = 0, w_rdy = 0;
    bit zero = (mt == 0) || (nt == 0) || (kt == 0);
    bus.op_valid = 1'b0; bus.res_ready = 1'b0;
    cfg_mt = CW'(mt); cfg_nt = CW'(nt); cfg_kt = CW'(kt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_mt = CW'($urandom); cfg_nt = CW'($urandom); cfg_kt = CW'($urandom_range(1, 3));
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (done) break;
      start = poke && (cyc == 2);
      if (start) chk("busy_at_poke", busy, 1'b1);
      if (bus.op_req) begin
        chk("op_idx", {bus.op_m_idx, bus.op_n_idx, bus.op_k_idx}, {CW'(em), CW'(en), CW'(ek)});
        if (w_op < op_dly) begin
          w_op++; bus.op_valid = 1'b0;
        end else begin
          w_op = 0; ops++;
          bus.op_valid = 1'b1; bus.op_a = pack_a(em, ek); bus.op_b = pack_b(ek, en);
          if (ek < kt - 1) ek++;
        end
      end else begin
        bus.op_valid = 1'($urandom); bus.op_a = a_t'($urandom); bus.op_b = b_t'($urandom);
      end
      if (bus.res_valid) begin
        chk("res_idx", {bus.res_m_idx, bus.res_n_idx}, {CW'(em), CW'(en)});
        chk("res_data", bus.res_data, exp_tile(em, en, kt));
        if (w_rdy < rdy_dly) begin
          w_rdy++; bus.res_ready = 1'b0;
        end else begin
          w_rdy = 0; ress++; last_hs = cyc; last_res = bus.res_data;
          bus.res_ready = 1'b1;
          ek = 0; en++;
          if (en == nt) begin en = 0; em++; end
        end
      end else begin
        bus.res_ready = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
    chk("busy_at_done", busy, 1'b1);
    chk("op_count", ops, mt * nt * kt);
    chk("res_count", ress, zero ? 0 : mt * nt);
    chk("done_latency", cyc, zero ? 0 : last_hs + 1);
    bus.op_valid = 1'b0; bus.res_ready = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_mt = '0; cfg_nt = '0; cfg_kt = '0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {bus.op_req, bus.res_valid, busy, done}, 4'b0);
    chk("rst_idx", {bus.op_m_idx, bus.op_n_idx, bus.op_k_idx}, 24'd0);
    chk("rst_kern", {bus.kern_a, bus.kern_b, bus.kern_c}, '0);
    rst = 1'b0;

    // Single tile
    fill_const(0, 0);
    ta[0][0][0][0] = 1; ta[0][0][0][1] = 2; ta[0][0][1][0] = 3; ta[0][0][1][1] = 4;
    tbt[0][0][0][0] = 5; tbt[0][0][0][1] = 6; tbt[0][0][1][0] = 7; tbt[0][0][1][1] = 8;
    run_job(1, 1, 1, 0, 0, 1'b0);
    chk("single_tile", last_res, {32'd50, 32'd43, 32'd22, 32'd19});

    // K accumulation: second k-step adds I * ones
    ta[0][1][0][0] = 1; ta[0][1][0][1] = 0; ta[0][1][1][0] = 0; ta[0][1][1][1] = 1;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) tbt[1][0][i][j] = 1;
    run_job(1, 1, 2, 0, 0, 1'b0);
    chk("k_accum", last_res, {32'd51, 32'd44, 32'd23, 32'd20});

    // Order, backpressure, delayed operands, start ignored while busy
    fill_rand();
    run_job(2, 2, 1, 3, 5, 1'b1);

    // Signed extremes
    fill_const(-128, -128);
    run_job(1, 1, 3, 1, 1, 1'b0);
    chk("neg_extreme", last_res, {4{32'd98304}});
    fill_const(-128, 127);
    run_job(1, 1, 3, 0, 2, 1'b0);
    chk("mixed_extreme", last_res, {4{-32'sd97536}});

    // Zero count
    run_job(2, 2, 0, 0, 0, 1'b0);

    // Reset mid-job during the second k-step fetch
    fill_rand();
    cfg_mt = 2; cfg_nt = 2; cfg_kt = 2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.op_req && bus.op_k_idx == 1) break;
      bus.op_valid = bus.op_req; bus.op_a = pack_a(0, 0); bus.op_b = pack_b(0, 0);
      @(posedge clk); #1;
    end
    chk("reach_fetch_k1", {bus.op_req, bus.op_k_idx}, {1'b1, CW'(1)});
    bus.op_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_outputs", {bus.op_req, bus.res_valid, busy, done}, 4'b0);
    chk("midrst_kern", {bus.kern_a, bus.kern_b, bus.kern_c}, '0);
    rst = 1'b0;
    run_job(1, 1, 1, 2, 1, 1'b0);

    // Randomized jobs
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
